// File: rtl/mux_usr_pkg.sv
// mux_usr_pkg: mode codes and FSM state encoding for the universal shift register
package mux_usr_pkg;
    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/mux_univ_shift_reg_if.sv
// mux_univ_shift_reg_if: control, data and status bundle of the universal shift register
interface mux_univ_shift_reg_if #(parameter int WIDTH = 8, parameter int CNT_W = 4);
    logic             en;
    logic             start;
    logic [2:0]       mode;
    logic [CNT_W-1:0] amount;
    logic             sin_lsb;
    logic             sin_msb;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             sout_msb;
    logic             sout_lsb;
    logic             busy;
    logic             done;

    modport master (
        output en, start, mode, amount, sin_lsb, sin_msb, d,
        input  q, sout_msb, sout_lsb, busy, done
    );
    modport slave (
        input  en, start, mode, amount, sin_lsb, sin_msb, d,
        output q, sout_msb, sout_lsb, busy, done
    );
endinterface

// File: rtl/mux_dff_cell.sv
// mux_dff_cell: 8:1 mux feeding an async-low-reset D flip-flop
module mux_dff_cell (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] sel,
    input  logic       in0,
    input  logic       in1,
    input  logic       in2,
    input  logic       in3,
    input  logic       in4,
    input  logic       in5,
    input  logic       in6,
    input  logic       in7,
    output logic       q
);
    logic [7:0] taps;

    assign taps = {in7, in6, in5, in4, in3, in2, in1, in0};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= 1'b0;
        else        q <= taps[sel];
endmodule

// File: rtl/mux_univ_shift_reg.sv
// mux_univ_shift_reg: universal shift register with free-run and counted-sequence modes
module mux_univ_shift_reg
    import mux_usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    mux_univ_shift_reg_if.slave  bus
);
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [2:0]       mode_q, mode_nx, sel;
    logic             done, done_nx;
    logic [WIDTH-1:0] q;

    // start wins over en; a launching start leaves q untouched on its own edge
    assign sel = (state == RUN) ? mode_q : (!bus.start && bus.en) ? bus.mode : MODE_HOLD;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        mode_nx  = mode_q;
        done_nx  = 1'b0;
        if (state == IDLE) begin
            if (bus.start && bus.amount != '0) begin
                state_nx = RUN;
                cnt_nx   = bus.amount;
                mode_nx  = bus.mode;
            end else if (bus.start) begin
                done_nx  = 1'b1;
            end
        end else begin
            cnt_nx = cnt - 1'b1;
            if (cnt == 1) begin
                state_nx = IDLE;
                done_nx  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            mode_q <= MODE_HOLD;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            mode_q <= mode_nx;
            done   <= done_nx;
        end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic shl_t, shr_t, rol_t, ror_t, asr_t;
        if (i == 0) begin : g_lo
            assign shl_t = bus.sin_lsb;
            assign rol_t = q[WIDTH-1];
        end else begin : g_lo
            assign shl_t = q[i-1];
            assign rol_t = q[i-1];
        end
        if (i == WIDTH - 1) begin : g_hi
            assign shr_t = bus.sin_msb;
            assign ror_t = q[0];
            assign asr_t = q[WIDTH-1];
        end else begin : g_hi
            assign shr_t = q[i+1];
            assign ror_t = q[i+1];
            assign asr_t = q[i+1];
        end
        mux_dff_cell u_cell (
            .clk  (clk),
            .rst_n(rst_n),
            .sel  (sel),
            .in0  (q[i]),
            .in1  (shl_t),
            .in2  (shr_t),
            .in3  (bus.d[i]),
            .in4  (rol_t),
            .in5  (ror_t),
            .in6  (asr_t),
            .in7  (1'b0),
            .q    (q[i])
        );
    end

    assign bus.q        = q;
    assign bus.sout_msb = q[WIDTH-1];
    assign bus.sout_lsb = q[0];
    assign bus.busy     = (state == RUN);
    assign bus.done     = done;
endmodule

// File: tb/tb_mux_univ_shift_reg.sv
// tb_mux_univ_shift_reg: directed scoreboard bench for the universal shift register
module tb_mux_univ_shift_reg;
    import mux_usr_pkg::*;

    typedef struct {
        string      tag;
        logic [7:0] q;
        logic       busy;
        logic       done;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    mux_univ_shift_reg_if #(.WIDTH(8), .CNT_W(4)) bus ();

    mux_univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [7:0] q, input logic busy, input logic done);
        exp_t e;
        e.tag = tag; e.q = q; e.busy = busy; e.done = done;
        sb.push_back(e);
    endtask

    task automatic compare();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        chk({e.tag, "_q"}, bus.q, e.q);
        chk({e.tag, "_busy"}, {7'd0, bus.busy}, {7'd0, e.busy});
        chk({e.tag, "_done"}, {7'd0, bus.done}, {7'd0, e.done});
        chk({e.tag, "_souts"}, {6'd0, bus.sout_msb, bus.sout_lsb}, {6'd0, e.q[7], e.q[0]});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic load(input logic [7:0] v);
        bus.start = 1'b0; bus.en = 1'b1; bus.mode = MODE_LOAD; bus.d = v;
        push("load", v, 1'b0, 1'b0);
        tick();
        bus.en = 1'b0;
    endtask

    initial begin
        logic [7:0] m;
        bus.en = 1'b1; bus.start = 1'b1; bus.mode = MODE_LOAD; bus.amount = 4'd7;
        bus.sin_lsb = 1'b1; bus.sin_msb = 1'b1; bus.d = 8'hFF;
        // 1: reset with busy inputs
        repeat (2) @(posedge clk);
        #1;
        push("reset", 8'h00, 1'b0, 1'b0);
        compare();
        bus.en = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        push("post_reset", 8'h00, 1'b0, 1'b0);
        tick();
        // 2: free-run LOAD then SHL
        load(8'hA5);
        bus.en = 1'b1; bus.mode = MODE_SHL; bus.sin_lsb = 1'b1;
        push("shl", 8'h4B, 1'b0, 1'b0);
        tick();
        bus.en = 1'b0;
        // 3: ROL by 3, mid-run start ignored
        load(8'h81);
        bus.start = 1'b1; bus.mode = MODE_ROL; bus.amount = 4'd3;
        push("rol_start", 8'h81, 1'b1, 1'b0);
        tick();
        bus.start = 1'b0;
        push("rol1", 8'h03, 1'b1, 1'b0);
        tick();
        bus.start = 1'b1; bus.mode = MODE_CLR; bus.amount = 4'd1;
        push("rol2", 8'h06, 1'b1, 1'b0);
        tick();
        bus.start = 1'b0;
        push("rol3", 8'h0C, 1'b0, 1'b1);
        tick();
        push("rol_after", 8'h0C, 1'b0, 1'b0);
        tick();
        // 4: ASR by 2 with en toggling
        load(8'h90);
        bus.start = 1'b1; bus.mode = MODE_ASR; bus.amount = 4'd2;
        push("asr_start", 8'h90, 1'b1, 1'b0);
        tick();
        bus.start = 1'b0; bus.en = 1'b1; bus.mode = MODE_LOAD; bus.d = 8'h00;
        push("asr1", 8'hC8, 1'b1, 1'b0);
        tick();
        bus.en = 1'b0;
        push("asr2", 8'hE4, 1'b0, 1'b1);
        tick();
        push("asr_after", 8'hE4, 1'b0, 1'b0);
        tick();
        // 5: zero-amount start
        load(8'h3C);
        bus.start = 1'b1; bus.mode = MODE_CLR; bus.amount = 4'd0;
        push("zero_amt", 8'h3C, 1'b0, 1'b1);
        tick();
        bus.start = 1'b0;
        push("zero_after", 8'h3C, 1'b0, 1'b0);
        tick();
        // 6: reset aborts SHR run
        load(8'h0F);
        bus.start = 1'b1; bus.mode = MODE_SHR; bus.amount = 4'd5; bus.sin_msb = 1'b1;
        push("shr_start", 8'h0F, 1'b1, 1'b0);
        tick();
        bus.start = 1'b0;
        push("shr1", 8'h87, 1'b1, 1'b0);
        tick();
        push("shr2", 8'hC3, 1'b1, 1'b0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        push("abort", 8'h00, 1'b0, 1'b0);
        compare();
        @(negedge clk);
        rst_n = 1'b1;
        push("abort_rel1", 8'h00, 1'b0, 1'b0);
        tick();
        push("abort_rel2", 8'h00, 1'b0, 1'b0);
        tick();
        load(8'h5A);
        // ROL by WIDTH returns the original value
        load(8'h6D);
        m = 8'h6D;
        bus.start = 1'b1; bus.mode = MODE_ROL; bus.amount = 4'd8;
        push("rol8_start", m, 1'b1, 1'b0);
        tick();
        bus.start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            m = {m[6:0], m[7]};
            push("rol8", m, i < 8, i == 8);
            tick();
        end
        chk("rol8_orig", bus.q, 8'h6D);
        // ROR and CLR free-run
        bus.en = 1'b1; bus.mode = MODE_ROR;
        push("ror", 8'hB6, 1'b0, 1'b0);
        tick();
        bus.mode = MODE_CLR;
        push("clr", 8'h00, 1'b0, 1'b0);
        tick();
        bus.en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
